cic_comb_mc: RTL and testbench

Multi-channel, variable-differential-delay comb stage for the decimating CIC path of the I2S/PDM receiver. It computes y[n] = x[n] - x[n-M] independently per channel, using modulo-2^WIDTH arithmetic. Channels arrive time-interleaved on one sample bus tagged with a channel index. Stages are cascaded after the integrator/decimator, and each stage carries its own valid/ready handshake and a registered output.

---
 rtl/cic_comb_mc.sv | 109 ++++++++++
 tb/tb_cic_comb_mc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_mc.sv
// Multi-channel comb stage: y[n] = x[n] - x[n-M] per channel, modulo 2^WIDTH.
// Channels arrive time-interleaved and are tagged with a channel index. The
// result sits in a single output register; its ready is passed straight back
// to the input side.
module cic_comb_mc #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned MAX_M  = 2,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned M_W   = $clog2(MAX_M + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic [M_W-1:0]   cfg_m_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CH_W-1:0]  in_ch_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CH_W-1:0]  out_ch_o,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int unsigned IDX_W = (MAX_M > 1) ? $clog2(MAX_M) : 1;

  // Per-channel history; index 0 holds the newest sample.
  logic [WIDTH-1:0] r_hist [NUM_CH][MAX_M];

  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic [WIDTH-1:0] r_out_data;

  logic [M_W-1:0]   w_m_eff;
  logic [IDX_W-1:0] w_tap;
  logic             w_ch_ok;
  logic [CH_W-1:0]  w_ch_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_diff;

  // Effective delay: 0 behaves as 1, anything above MAX_M is clamped.
  always_comb begin
    w_m_eff = cfg_m_i;
    if (cfg_m_i == '0) begin
      w_m_eff = M_W'(1);
    end else if (cfg_m_i > M_W'(MAX_M)) begin
      w_m_eff = M_W'(MAX_M);
    end
  end

  assign w_tap      = IDX_W'(w_m_eff - M_W'(1));
  assign w_ch_ok    = (CH_W + 1)'(in_ch_i) < (CH_W + 1)'(NUM_CH);
  assign w_ch_idx   = w_ch_ok ? in_ch_i : '0;
  assign in_ready_o = ~clr_i & (~r_out_valid | out_ready_i);
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_diff     = in_data_i - r_hist[w_ch_idx][w_tap];

  // History shift for the accepted channel only; clear wipes all channels.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < MAX_M; k++) begin
          r_hist[c][k] <= '0;
        end
      end
    end else if (clr_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < MAX_M; k++) begin
          r_hist[c][k] <= '0;
        end
      end
    end else if (w_accept && w_ch_ok) begin
      for (int k = MAX_M - 1; k > 0; k--) begin
        r_hist[w_ch_idx][k] <= r_hist[w_ch_idx][k-1];
      end
      r_hist[w_ch_idx][0] <= in_data_i;
    end
  end

  // Output register: load on a valid-channel accept, drain on handshake, else hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else if (clr_i) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      if (w_ch_ok) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= in_ch_i;
        r_out_data  <= w_diff;
      end else begin
        // Dropped channel: slot is free (old output consumed or absent).
        r_out_valid <= 1'b0;
      end
    end else if (r_out_valid && out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_ch_o    = r_out_ch;
  assign out_data_o  = r_out_data;

endmodule

// File: tb/tb_cic_comb_mc.sv
// Directed bench for cic_comb_mc (WIDTH=16, NUM_CH=3, MAX_M=2).
module tb_cic_comb_mc;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned MAX_M  = 2;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              clr_i;
  logic [1:0]        cfg_m_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        in_ch_i;
  logic [WIDTH-1:0]  in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [1:0]        out_ch_o;
  logic [WIDTH-1:0]  out_data_o;

  int n_assert = 0;
  int n_fail   = 0;

  cic_comb_mc #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_M(MAX_M)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clr_i       (clr_i),
    .cfg_m_i     (cfg_m_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ch_i     (in_ch_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ch_o    (out_ch_o),
    .out_data_o  (out_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [WIDTH-1:0] d);
    in_valid_i = 1'b1;
    in_ch_i    = ch;
    in_data_i  = d;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] ch, input logic [WIDTH-1:0] d);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    check({tag, "_ch"},    64'(out_ch_o),    64'(ch));
    check({tag, "_data"},  64'(out_data_o),  64'(d));
  endtask

  task automatic do_clear();
    in_valid_i = 1'b0;
    clr_i      = 1'b1;
    tick();
    clr_i      = 1'b0;
  endtask

  initial begin
    rstn_i      = 1'b0;
    clr_i       = 1'b0;
    cfg_m_i     = 2'd1;
    in_valid_i  = 1'b0;
    in_ch_i     = '0;
    in_data_i   = '0;
    out_ready_i = 1'b1;
    #2;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data",  64'(out_data_o),  64'd0);
    check("rst_ch",    64'(out_ch_o),    64'd0);
    tick();
    tick();
    rstn_i = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready_o), 64'd1);

    // 1: reset mid-transfer, then ch0 sample 7
    send(2'd1, 16'd50);
    expect_out("t1_pre", 2'd1, 16'd50);
    rstn_i = 1'b0;
    #1;
    check("t1_rst_valid", 64'(out_valid_o), 64'd0);
    check("t1_rst_data",  64'(out_data_o),  64'd0);
    in_valid_i = 1'b0;
    #2;
    rstn_i = 1'b1;
    #1;
    check("t1_ready", 64'(in_ready_o), 64'd1);
    send(2'd0, 16'd7);
    expect_out("t1_s7", 2'd0, 16'd7);
    // ch1 history must have been wiped by the reset
    send(2'd1, 16'd20);
    expect_out("t1_ch1", 2'd1, 16'd20);

    // 2: M=1 back-to-back on a fresh channel
    send(2'd2, 16'd5);
    expect_out("t2_a", 2'd2, 16'h0005);
    send(2'd2, 16'd9);
    expect_out("t2_b", 2'd2, 16'h0004);
    send(2'd2, 16'd4);
    expect_out("t2_c", 2'd2, 16'hFFFB);

    // 3: M=2 warm-up and steady state, then clamp and zero handling
    in_valid_i = 1'b0;
    clr_i      = 1'b1;
    #1;
    check("t3_clr_ready", 64'(in_ready_o), 64'd0);
    tick();
    clr_i = 1'b0;
    check("t3_clr_valid", 64'(out_valid_o), 64'd0);
    check("t3_clr_data",  64'(out_data_o),  64'd0);
    cfg_m_i = 2'd2;
    send(2'd0, 16'd1);
    expect_out("t3_a", 2'd0, 16'd1);
    send(2'd0, 16'd2);
    expect_out("t3_b", 2'd0, 16'd2);
    send(2'd0, 16'd3);
    expect_out("t3_c", 2'd0, 16'd2);
    send(2'd0, 16'd4);
    expect_out("t3_d", 2'd0, 16'd2);
    cfg_m_i = 2'd3;
    send(2'd0, 16'd10);
    expect_out("t3_clamp_a", 2'd0, 16'd7);
    send(2'd0, 16'd13);
    expect_out("t3_clamp_b", 2'd0, 16'd9);
    cfg_m_i = 2'd0;
    send(2'd0, 16'd20);
    expect_out("t3_zero", 2'd0, 16'd7);

    // 4: interleaved channels, then an out-of-range channel
    do_clear();
    cfg_m_i = 2'd1;
    send(2'd0, 16'd10);
    expect_out("t4_a", 2'd0, 16'd10);
    send(2'd1, 16'd100);
    expect_out("t4_b", 2'd1, 16'd100);
    send(2'd0, 16'd30);
    expect_out("t4_c", 2'd0, 16'd20);
    send(2'd1, 16'd70);
    expect_out("t4_d", 2'd1, 16'hFFE2);
    send(2'd3, 16'd999);
    check("t4_drop_valid", 64'(out_valid_o), 64'd0);
    check("t4_drop_data",  64'(out_data_o),  64'hFFE2);
    send(2'd0, 16'd35);
    expect_out("t4_e", 2'd0, 16'd5);
    send(2'd1, 16'd75);
    expect_out("t4_f", 2'd1, 16'd5);

    // 5: backpressure, then wrap-around
    do_clear();
    send(2'd1, 16'h0011);
    expect_out("t5_load", 2'd1, 16'h0011);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_ch_i     = 2'd1;
    in_data_i   = 16'h0030;
    #1;
    check("t5_ready_lo", 64'(in_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t5_stall", 2'd1, 16'h0011);
      check("t5_stall_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    #1;
    check("t5_ready_hi", 64'(in_ready_o), 64'd1);
    tick();
    expect_out("t5_held", 2'd1, 16'h001F);
    send(2'd0, 16'hFFFE);
    expect_out("t5_w1", 2'd0, 16'hFFFE);
    send(2'd0, 16'h0003);
    expect_out("t5_w2", 2'd0, 16'h0005);
    in_valid_i = 1'b0;
    tick();
    check("t5_drain_valid", 64'(out_valid_o), 64'd0);
    check("t5_drain_data",  64'(out_data_o),  64'h0005);

    // 6: clear while an output is pending
    send(2'd0, 16'h0100);
    expect_out("t6_pre", 2'd0, 16'h00FD);
    clr_i      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 16'h0055;
    tick();
    clr_i = 1'b0;
    check("t6_clr_valid", 64'(out_valid_o), 64'd0);
    check("t6_clr_data",  64'(out_data_o),  64'd0);
    check("t6_clr_ch",    64'(out_ch_o),    64'd0);
    send(2'd0, 16'h1234);
    expect_out("t6_post", 2'd0, 16'h1234);
    in_valid_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
